// File: rtl/pr_pkg.sv
// ============================================================================
// pr_pkg : shared AXI/memory constants and stream id assignments | Rev 1.0
// ============================================================================
`default_nettype none

package pr_pkg;

    localparam int LINE_W   = 512;
    localparam int AXI_ID_W = 16;

    localparam logic [AXI_ID_W-1:0] ID_VERTEX   = 16'd0;
    localparam logic [AXI_ID_W-1:0] ID_INEDGE   = 16'd1;
    localparam logic [AXI_ID_W-1:0] ID_PAGERANK = 16'd2;

    // AXI arsize: log2 of the beat size in bytes.
    function automatic logic [2:0] axsize(input int bytes);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) s = 3'(i);
        end
        return s;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } sr_state_e;

endpackage

`default_nettype wire

// File: rtl/HullFIFO.sv
// ============================================================================
// HullFIFO : first-word-fall-through line buffer with occupancy count | Rev 1.0
// ============================================================================
`default_nettype none

module HullFIFO #(
    parameter int WIDTH     = 512,
    parameter int LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 empty_o,
    output logic [LOG_DEPTH:0]   count_o
);

    localparam int c_DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem_q [c_DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   count_q,  count_d;
    logic                 w_wr, w_rd;

    assign w_wr = push_i && (count_q != (LOG_DEPTH+1)'(c_DEPTH));
    assign w_rd = pop_i  && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        // Push and pop in the same cycle leave occupancy unchanged.
        case ({w_wr, w_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/stream_reader.sv
// ============================================================================
// stream_reader : AXI line reader that streams fixed-width elements | Rev 1.0
// ============================================================================
`default_nettype none

module stream_reader
    import pr_pkg::*;
#(
    parameter int LINE_W    = pr_pkg::LINE_W,
    parameter int ELEM_W    = 64,
    parameter int ID        = 0,
    parameter int LOG_DEPTH = 3,
    parameter int MAX_OUT   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [63:0]          base_addr,
    input  logic [63:0]          n_elems,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          arid_m,
    output logic [63:0]          araddr_m,
    output logic [7:0]           arlen_m,
    output logic [2:0]           arsize_m,
    output logic                 arvalid_m,
    input  logic                 arready_m,
    input  logic [15:0]          rid_m,
    input  logic [LINE_W-1:0]    rdata_m,
    input  logic [1:0]           rresp_m,
    input  logic                 rlast_m,
    input  logic                 rvalid_m,
    output logic                 rready_m,
    output logic                 out_valid,
    output logic [ELEM_W-1:0]    out_data,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int c_EPL     = LINE_W / ELEM_W;
    localparam int c_LB      = $clog2(LINE_W / 8);
    localparam int c_EB      = $clog2(ELEM_W / 8);
    localparam int c_EPL_LOG = $clog2(c_EPL);
    localparam int c_IDX_W   = (c_EPL > 1) ? c_EPL_LOG : 1;
    localparam int c_CNT_W   = LOG_DEPTH + 1;
    localparam int c_DEPTH   = 1 << LOG_DEPTH;
    localparam logic [AXI_ID_W-1:0] c_ID         = AXI_ID_W'(ID);
    localparam logic [63:0]         c_LINE_BYTES = 64'(LINE_W / 8);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST   = c_IDX_W'(c_EPL - 1);

    sr_state_e            state_q, state_d;
    logic [63:0]          lines_left_q, lines_left_d;
    logic [63:0]          araddr_q, araddr_d;
    logic [63:0]          elems_left_q, elems_left_d;
    logic [c_CNT_W-1:0]   outst_q, outst_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic                 err_q, err_d;

    logic [c_IDX_W-1:0]   w_off;
    logic [64:0]          w_lines_sum;
    logic [63:0]          w_lines;
    logic                 w_credit, w_ar_hs, w_push, w_pop, w_out_hs, w_last;
    logic [LINE_W-1:0]    w_head;
    logic                 w_empty;
    logic [LOG_DEPTH:0]   w_count;
    logic                 w_unused_ok;

    generate
        if (c_EPL > 1) begin : g_off
            assign w_off = base_addr[c_LB-1:c_EB];
        end else begin : g_off_none
            assign w_off = '0;
        end
    endgenerate

    // Lines touched = ceil((offset + n) / EPL), computed one bit wider.
    assign w_lines_sum = {1'b0, n_elems} + 65'(w_off) + 65'(c_EPL - 1);
    assign w_lines     = 64'(w_lines_sum >> c_EPL_LOG);

    // Credit counts outstanding plus buffered lines so the buffer never overflows.
    assign w_credit  = (32'(outst_q) < MAX_OUT) &&
                       ((32'(outst_q) + 32'(w_count)) < c_DEPTH);
    assign arvalid_m = (state_q == ST_RUN) && (lines_left_q != '0) && w_credit;
    assign w_ar_hs   = arvalid_m && arready_m;

    assign w_push    = (state_q == ST_RUN) && rvalid_m && (rid_m == c_ID);
    assign out_valid = (state_q == ST_RUN) && !w_empty;
    assign w_out_hs  = out_valid && out_ready;
    assign w_last    = (elems_left_q == 64'd1);
    assign w_pop     = w_out_hs && ((idx_q == c_IDX_LAST) || w_last);

    always_comb begin
        state_d      = state_q;
        lines_left_d = lines_left_q;
        araddr_d     = araddr_q;
        elems_left_d = elems_left_q;
        outst_d      = outst_q;
        idx_d        = idx_q;
        err_d        = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    araddr_d     = base_addr & ~(c_LINE_BYTES - 64'd1);
                    idx_d        = w_off;
                    lines_left_d = w_lines;
                    elems_left_d = n_elems;
                    outst_d      = '0;
                    err_d        = 1'b0;
                    state_d      = (n_elems == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_ar_hs) begin
                    lines_left_d = lines_left_q - 64'd1;
                    araddr_d     = araddr_q + c_LINE_BYTES;
                end
                case ({w_ar_hs, w_push})
                    2'b10:   outst_d = outst_q + 1'b1;
                    2'b01:   outst_d = (outst_q != '0) ? outst_q - 1'b1 : outst_q;
                    default: outst_d = outst_q;
                endcase
                if (w_push && (rresp_m != 2'b00)) err_d = 1'b1;
                if (w_out_hs) begin
                    idx_d        = w_pop ? '0 : idx_q + 1'b1;
                    elems_left_d = elems_left_q - 64'd1;
                    if (w_last) state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            lines_left_q <= '0;
            araddr_q     <= '0;
            elems_left_q <= '0;
            outst_q      <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lines_left_q <= lines_left_d;
            araddr_q     <= araddr_d;
            elems_left_q <= elems_left_d;
            outst_q      <= outst_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
        end
    end

    HullFIFO #(
        .WIDTH     (LINE_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_line_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_push),
        .wdata_i (rdata_m),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign arid_m   = c_ID;
    assign araddr_m = araddr_q;
    assign arlen_m  = 8'd0;
    assign arsize_m = axsize(LINE_W / 8);
    assign rready_m = 1'b1;
    assign out_data = w_head[idx_q*ELEM_W +: ELEM_W];
    assign out_last = out_valid && w_last;
    assign done     = (state_q == ST_FIN);
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

    // Element sub-offset bits and rlast carry no information for single-beat reads.
    assign w_unused_ok = &{1'b0, base_addr[c_LB-1:0], rlast_m};

endmodule

`default_nettype wire

// File: tb/tb_stream_reader.sv
// ============================================================================
// tb_stream_reader : table-driven bench with a behavioural AXI memory | Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_reader;

    logic          clk = 1'b0;
    logic          reset_n, start;
    logic [63:0]   base_addr, n_elems;
    logic          busy, done, err;
    logic [15:0]   arid_m;
    logic [63:0]   araddr_m;
    logic [7:0]    arlen_m;
    logic [2:0]    arsize_m;
    logic          arvalid_m, arready_m;
    logic [15:0]   rid_m;
    logic [511:0]  rdata_m;
    logic [1:0]    rresp_m;
    logic          rlast_m, rvalid_m, rready_m;
    logic          out_valid, out_last, out_ready;
    logic [63:0]   out_data;

    stream_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .n_elems(n_elems), .busy(busy), .done(done), .err(err),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory image: each 64-bit slot holds its own byte address.
    function automatic logic [511:0] line_data(input logic [63:0] a);
        logic [511:0] d;
        for (int s = 0; s < 8; s++) d[s*64 +: 64] = a + 64'(8 * s);
        return d;
    endfunction

    // ---------------- behavioural AXI memory (one beat per cycle) ----------------
    bit           fg_mode = 1'b0;
    bit           ar_stall = 1'b0;
    bit           stale_pulse = 1'b0;
    int           err_at = -1;
    int           mcyc = 0;
    logic [63:0]  just_a[$], av_a[$], ar_log[$];
    int           just_s[$], av_s[$];
    bit           prev_wait = 1'b0;
    logic [63:0]  prev_addr = '0;
    int           hold_checks = 0, hold_viol = 0;

    always @(negedge clk) begin : p_mem
        logic [63:0] a;
        int          s;
        mcyc++;
        rvalid_m = 1'b0; rid_m = '0; rresp_m = '0; rlast_m = 1'b0; rdata_m = '0;
        if (!reset_n) begin
            just_a.delete(); just_s.delete(); av_a.delete(); av_s.delete();
            arready_m = 1'b1;
            prev_wait = 1'b0;
        end else begin
            while (just_a.size() > 0) begin
                av_a.push_back(just_a.pop_front());
                av_s.push_back(just_s.pop_front());
            end
            if (stale_pulse) begin
                rvalid_m = 1'b1; rid_m = 16'h0000; rlast_m = 1'b1;
                rdata_m = {8{64'hdead_beef_0bad_f00d}};
            end else if (fg_mode && mcyc[0]) begin
                rvalid_m = 1'b1; rid_m = 16'h0001; rlast_m = 1'b1;
                rdata_m = {8{64'hf0f0_1234_5678_0f0f}};
            end else if (av_a.size() > 0) begin
                a = av_a.pop_front();
                s = av_s.pop_front();
                rvalid_m = 1'b1; rid_m = 16'h0000; rlast_m = 1'b1;
                rdata_m = line_data(a);
                rresp_m = (s == err_at) ? 2'b10 : 2'b00;
            end
            arready_m = ar_stall ? ((mcyc % 3) != 0) : 1'b1;
            if (prev_wait) begin
                hold_checks++;
                if (!arvalid_m || araddr_m !== prev_addr) hold_viol++;
            end
            prev_wait = arvalid_m && !arready_m;
            prev_addr = araddr_m;
            if (arvalid_m && arready_m) begin
                ar_log.push_back(araddr_m);
                just_a.push_back(araddr_m);
                just_s.push_back(ar_log.size() - 1);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [63:0] base;
        logic [63:0] n;
        int          stall;
        bit          slow_rdy;
        bit          ar_stall;
        bit          foreign;
        bit          inj_err;
        int          exp_lines;
        logic [63:0] exp_first;
        bit          exp_err;
        bit          tput;
    } vec_t;

    vec_t vecs[10];

    task automatic run_row(input int r, input vec_t v);
        int          base_idx, k, cyc, stall_left, gaps, nar;
        bit          first_seen, have_held, held_ok, seq_ok;
        logic [63:0] held, exp_d;
        string       tag;
        tag = $sformatf("row%0d", r);
        @(negedge clk);
        base_idx  = ar_log.size();
        fg_mode   = v.foreign;
        ar_stall  = v.ar_stall;
        err_at    = v.inj_err ? base_idx : -1;
        base_addr = v.base;
        n_elems   = v.n;
        out_ready = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.n == 64'd0) begin
            chk({tag, "_zero_done"}, {63'd0, done}, 64'd1);
            @(negedge clk);
            chk({tag, "_zero_done_off"}, {62'd0, done, busy}, 64'd0);
            chk({tag, "_zero_no_ar"}, 64'(ar_log.size() - base_idx), 64'd0);
            return;
        end
        chk({tag, "_busy"}, {62'd0, busy, done}, 64'd2);
        k = 0; cyc = 0; gaps = 0; stall_left = v.stall;
        first_seen = 0; have_held = 0; held_ok = 1; held = '0;
        while (64'(k) < v.n && cyc < 3000) begin
            if (stall_left > 0) out_ready = 1'b0;
            else                out_ready = v.slow_rdy ? ((cyc % 3) != 1) : 1'b1;
            if (stall_left > 0) begin
                if (out_valid) begin
                    if (!have_held) begin held = out_data; have_held = 1; end
                    else if (out_data !== held) held_ok = 0;
                end
                stall_left--;
                if (stall_left == 0) begin
                    nar = (v.exp_lines < 8) ? v.exp_lines : 8;
                    chk({tag, "_stall_ar_count"}, 64'(ar_log.size() - base_idx), 64'(nar));
                    chk({tag, "_stall_data_stable"}, {62'd0, have_held, held_ok}, 64'd3);
                end
            end
            if (out_valid) first_seen = 1;
            else if (first_seen) gaps++;
            if (out_valid && out_ready) begin
                exp_d = (v.base & ~64'h7) + 64'(8 * k);
                chk($sformatf("%s_data%0d", tag, k), out_data, exp_d);
                chk($sformatf("%s_last%0d", tag, k), {63'd0, out_last},
                    {63'd0, (64'(k) == v.n - 64'd1)});
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (64'(k) < v.n) chk({tag, "_timeout_elems"}, 64'(k), v.n);
        chk({tag, "_done_pulse"}, {62'd0, done, out_valid}, 64'd2);
        chk({tag, "_err"}, {63'd0, err}, {63'd0, v.exp_err});
        @(negedge clk);
        chk({tag, "_idle_after"}, {61'd0, done, busy, out_valid}, 64'd0);
        chk({tag, "_ar_count"}, 64'(ar_log.size() - base_idx), 64'(v.exp_lines));
        if (ar_log.size() > base_idx) begin
            chk({tag, "_ar_first"}, ar_log[base_idx], v.exp_first);
            seq_ok = 1;
            for (int i = base_idx + 1; i < ar_log.size(); i++)
                if (ar_log[i] !== ar_log[i-1] + 64'h40) seq_ok = 0;
            chk({tag, "_ar_sequential"}, {63'd0, seq_ok}, 64'd1);
        end
        if (v.tput) chk({tag, "_gap_cycles"}, 64'(gaps), 64'd0);
        fg_mode = 1'b0; ar_stall = 1'b0; err_at = -1;
    endtask

    initial begin : p_main
        int          k, cyc, snap;
        bit          quiet;
        vecs[0] = '{64'h1000, 64'd16,  0, 0, 0, 0, 0,  2, 64'h1000, 0, 1};
        vecs[1] = '{64'h1018, 64'd6,   0, 0, 0, 0, 0,  2, 64'h1000, 0, 0};
        vecs[2] = '{64'h4000, 64'd64, 50, 0, 0, 0, 0,  8, 64'h4000, 0, 0};
        vecs[3] = '{64'h8000, 64'd128,50, 0, 0, 0, 0, 16, 64'h8000, 0, 0};
        vecs[4] = '{64'h2000, 64'd40,  0, 1, 1, 1, 1,  5, 64'h2000, 1, 0};
        vecs[5] = '{64'h6000, 64'd64,  0, 0, 0, 0, 0,  8, 64'h6000, 0, 1};
        vecs[6] = '{64'h1038, 64'd9,   0, 0, 0, 0, 0,  2, 64'h1000, 0, 0};
        vecs[7] = '{64'h7005, 64'd1,   0, 0, 0, 0, 0,  1, 64'h7000, 0, 0};
        vecs[8] = '{64'h5000, 64'd0,   0, 0, 0, 0, 0,  0, 64'h0,    0, 0};
        vecs[9] = '{64'h9ff8, 64'd1,   0, 0, 0, 0, 0,  1, 64'h9fc0, 0, 0};

        reset_n = 1'b0; start = 1'b0; base_addr = '0; n_elems = '0; out_ready = 1'b0;
        #1;
        chk("reset_outputs", {58'd0, busy, done, err, arvalid_m, out_valid, out_last}, 64'd0);
        chk("reset_rready", {63'd0, rready_m}, 64'd1);
        chk("ar_fields", {40'd0, arid_m, arlen_m}, 64'd0);
        chk("ar_size", {61'd0, arsize_m}, 64'd6);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", {61'd0, busy, arvalid_m, out_valid}, 64'd0);

        for (int r = 0; r < 10; r++) run_row(r, vecs[r]);

        chk("ar_hold_violations", 64'(hold_viol), 64'd0);
        chk("ar_hold_exercised", {63'd0, (hold_checks > 0)}, 64'd1);

        // Reset in the middle of a stream, then a stale beat, then an empty stream.
        @(negedge clk);
        base_addr = 64'h3000; n_elems = 64'd32; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; cyc = 0;
        while (k < 3 && cyc < 200) begin
            if (out_valid && out_ready) k++;
            if (k < 3) begin @(negedge clk); cyc++; end
        end
        chk("midrst_three_elems", 64'(k), 64'd3);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_outputs", {59'd0, busy, done, err, arvalid_m, out_valid}, 64'd0);
        chk("midrst_rready", {62'd0, rready_m, out_last}, 64'd2);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        snap = ar_log.size();
        @(posedge clk); stale_pulse = 1'b1;
        @(posedge clk); stale_pulse = 1'b0;
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid || busy || arvalid_m) quiet = 0;
        end
        chk("stale_beat_dropped", {63'd0, quiet}, 64'd1);
        base_addr = 64'hA000; n_elems = 64'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("post_rst_zero_done", {62'd0, done, out_valid}, 64'd2);
        @(negedge clk);
        chk("post_rst_zero_idle", {62'd0, done, busy}, 64'd0);
        chk("post_rst_no_ar", 64'(ar_log.size() - snap), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
